teller_dispatch: RTL and testbench

//  Service-side counterpart of the customer-queue counter. It holds the waiting count
//   and issues ticket numbers to arriving customers.
//  It also calls the next ticket to a free teller, using round-robin across 3 tellers.

---
 rtl/teller_dispatch_pkg.sv | 42 ++++
 rtl/teller_dispatch_if.sv | 35 +++
 rtl/teller_dispatch_seg7_hex.sv | 15 +
 rtl/teller_dispatch.sv | 164 ++++++++++++++++
 tb/tb_teller_dispatch.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/teller_dispatch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : teller_dispatch_pkg
//  Purpose  : Shared state encodings, teller count and hex seven-segment table.
//  Revision : 1.0 - initial release
// ============================================================================
package teller_dispatch_pkg;

    localparam int NTELLER = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALL = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    // Active-high {g,f,e,d,c,b,a}; same table as the waiting-time ROM display.
    function automatic logic [6:0] hex_to_seg7(input logic [3:0] digit);
        logic [6:0] segs;
        case (digit)
            4'h0: segs = 7'h3F;
            4'h1: segs = 7'h06;
            4'h2: segs = 7'h5B;
            4'h3: segs = 7'h4F;
            4'h4: segs = 7'h66;
            4'h5: segs = 7'h6D;
            4'h6: segs = 7'h7D;
            4'h7: segs = 7'h07;
            4'h8: segs = 7'h7F;
            4'h9: segs = 7'h6F;
            4'hA: segs = 7'h77;
            4'hB: segs = 7'h7C;
            4'hC: segs = 7'h39;
            4'hD: segs = 7'h5E;
            4'hE: segs = 7'h79;
            default: segs = 7'h71;
        endcase
        return segs;
    endfunction

endpackage
`default_nettype wire

// File: rtl/teller_dispatch_if.sv
`default_nettype none
// ============================================================================
//  Module   : teller_dispatch_if
//  Purpose  : Arrival/teller inputs and queue/call/display outputs of the dispatcher.
//  Revision : 1.0 - initial release
// ============================================================================
interface teller_dispatch_if #(
    parameter int TW = 4
) ();
    logic          arrive;
    logic [2:0]    teller_done;
    logic [TW-1:0] issued_ticket;
    logic [2:0]    wait_cnt;
    logic          empty;
    logic          full;
    logic          overflow;
    logic [2:0]    busy;
    logic          call_valid;
    logic [1:0]    call_teller;
    logic [TW-1:0] call_ticket;
    logic [7:0]    seg;

    modport master (
        output arrive, teller_done,
        input  issued_ticket, wait_cnt, empty, full, overflow,
               busy, call_valid, call_teller, call_ticket, seg
    );

    modport slave (
        input  arrive, teller_done,
        output issued_ticket, wait_cnt, empty, full, overflow,
               busy, call_valid, call_teller, call_ticket, seg
    );
endinterface
`default_nettype wire

// File: rtl/teller_dispatch_seg7_hex.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_hex
//  Purpose  : Combinational 4-bit hex digit to 7-segment decoder.
//  Revision : 1.0 - initial release
// ============================================================================
module seg7_hex
    import teller_dispatch_pkg::*;
(
    input  wire  [3:0] i_digit,
    output logic [6:0] o_seg
);
    assign o_seg = hex_to_seg7(i_digit);
endmodule
`default_nettype wire

// File: rtl/teller_dispatch.sv
`default_nettype none
// ============================================================================
//  Module   : teller_dispatch
//  Purpose  : Ticket issue, waiting count and round-robin teller calls with display.
//  Revision : 1.0 - initial release
// ============================================================================
module teller_dispatch
    import teller_dispatch_pkg::*;
#(
    parameter int QDEPTH   = 7,
    parameter int TW       = 4,
    parameter int HOLD_CYC = 4
) (
    input wire clka,
    input wire reset,
    teller_dispatch_if.slave bus
);
    localparam int                c_HOLD_W    = $clog2(HOLD_CYC + 1);
    localparam logic [2:0]        c_QDEPTH    = 3'(QDEPTH);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_CYC - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [TW-1:0]       r_issue_ptr;
    logic [TW-1:0]       r_serve_ptr;
    logic [TW-1:0]       r_issued_ticket;
    logic [TW-1:0]       r_call_ticket;
    logic [2:0]          r_wait_cnt;
    logic [2:0]          r_busy;
    logic [1:0]          r_last_grant;
    logic [1:0]          r_grant;
    logic [1:0]          r_call_teller;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic                r_overflow;

    logic       w_full;
    logic       w_accept;
    logic       w_in_call;
    logic       w_start;
    logic       w_hold_done;
    logic [1:0] w_pick;
    logic [2:0] w_busy_nxt;
    logic [6:0] w_seg7;

    // First free teller searching upward from last+1, wrapping over NTELLER.
    function automatic logic [1:0] rr_pick(input logic [2:0] free, input logic [1:0] last);
        logic [1:0] pick;
        logic [1:0] idx;
        logic       found;
        pick  = 2'd0;
        found = 1'b0;
        for (int k = 1; k <= NTELLER; k++) begin
            idx = 2'((int'(last) + k) % NTELLER);
            if (!found && free[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign w_full      = (r_wait_cnt == c_QDEPTH);
    assign w_accept    = bus.arrive && !w_full;
    assign w_in_call   = (r_state == ST_CALL);
    assign w_hold_done = (r_hold_cnt == c_HOLD_LAST);
    assign w_pick      = rr_pick(~r_busy, r_last_grant);
    assign w_busy_nxt  = (r_busy & ~bus.teller_done) | (w_in_call ? (3'b001 << r_grant) : 3'b000);

    always_ff @(posedge clka) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if ((r_wait_cnt != 3'd0) && ((~r_busy) != 3'b000)) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_CALL;
                end
            end
            ST_CALL: w_state_nxt = ST_HOLD;
            ST_HOLD: begin
                if (w_hold_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clka) begin
        if (reset) begin
            r_issue_ptr     <= '0;
            r_serve_ptr     <= '0;
            r_issued_ticket <= '0;
            r_call_ticket   <= '0;
            r_wait_cnt      <= 3'd0;
            r_busy          <= 3'b000;
            // Starting the search from the last teller makes teller 1 the first grant.
            r_last_grant    <= 2'(NTELLER - 1);
            r_grant         <= 2'd0;
            r_call_teller   <= 2'd0;
            r_hold_cnt      <= '0;
            r_overflow      <= 1'b0;
        end else begin
            r_overflow <= bus.arrive && w_full;
            r_busy     <= w_busy_nxt;

            if (w_accept) begin
                r_issued_ticket <= r_issue_ptr;
                r_issue_ptr     <= r_issue_ptr + 1'b1;
            end

            case ({w_accept, w_in_call})
                2'b10:   r_wait_cnt <= r_wait_cnt + 3'd1;
                2'b01:   r_wait_cnt <= r_wait_cnt - 3'd1;
                default: r_wait_cnt <= r_wait_cnt;
            endcase

            if (w_start) begin
                r_grant       <= w_pick;
                r_call_teller <= w_pick + 2'd1;
                r_call_ticket <= r_serve_ptr;
            end

            if (w_in_call) begin
                r_serve_ptr  <= r_serve_ptr + 1'b1;
                r_last_grant <= r_grant;
            end

            if (r_state == ST_HOLD) begin
                r_hold_cnt <= w_hold_done ? '0 : r_hold_cnt + 1'b1;
                if (w_hold_done) begin
                    r_call_teller <= 2'd0;
                end
            end else begin
                r_hold_cnt <= '0;
            end
        end
    end

    seg7_hex u_seg7_hex (
        .i_digit (r_call_ticket[3:0]),
        .o_seg   (w_seg7)
    );

    assign bus.issued_ticket = r_issued_ticket;
    assign bus.wait_cnt      = r_wait_cnt;
    assign bus.empty         = (r_wait_cnt == 3'd0);
    assign bus.full          = w_full;
    assign bus.overflow      = r_overflow;
    assign bus.busy          = r_busy;
    assign bus.call_valid    = w_in_call;
    assign bus.call_teller   = r_call_teller;
    assign bus.call_ticket   = r_call_ticket;
    assign bus.seg           = {(r_state == ST_CALL) || (r_state == ST_HOLD), w_seg7};
endmodule
`default_nettype wire

// File: tb/tb_teller_dispatch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_teller_dispatch
//  Purpose  : Directed self-checking bench for teller_dispatch.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_teller_dispatch;
    logic clka;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_fails;

    teller_dispatch_if #(.TW(4)) bus ();

    teller_dispatch #(
        .QDEPTH   (7),
        .TW       (4),
        .HOLD_CYC (4)
    ) dut (
        .clka  (clka),
        .reset (reset),
        .bus   (bus)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    initial cyc = 0;
    always @(posedge clka) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clka);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_issued"}, 32'(bus.issued_ticket), 0);
        check_eq({tag, "_wait"},   32'(bus.wait_cnt), 0);
        check_eq({tag, "_empty"},  32'(bus.empty), 1);
        check_eq({tag, "_full"},   32'(bus.full), 0);
        check_eq({tag, "_ovf"},    32'(bus.overflow), 0);
        check_eq({tag, "_busy"},   32'(bus.busy), 0);
        check_eq({tag, "_cvalid"}, 32'(bus.call_valid), 0);
        check_eq({tag, "_cteller"},32'(bus.call_teller), 0);
        check_eq({tag, "_cticket"},32'(bus.call_ticket), 0);
        check_eq({tag, "_seg"},    32'(bus.seg), 32'h3F);
    endtask

    task automatic wait_call(input int budget, output int at_cyc);
        int n;
        n = 0;
        step();
        while (bus.call_valid !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        check_eq("call_seen", 32'(bus.call_valid), 1);
        at_cyc = cyc;
    endtask

    int   c1, c2, c3, c4, c5;
    int   ov_cnt, nc;
    int   m_issue, m_serve, m_teller, wb;
    logic drive_arr, saw_call;

    initial begin
        n_checks        = 0;
        n_fails         = 0;
        reset           = 1'b1;
        bus.arrive      = 1'b0;
        bus.teller_done = 3'b000;
        repeat (2) step();
        reset = 1'b0;
        check_reset_vals("rst");

        // Three back-to-back arrivals; first call one cycle after first acceptance
        bus.arrive = 1'b1;
        step();
        check_eq("t1_issued0", 32'(bus.issued_ticket), 0);
        check_eq("t1_wait1",   32'(bus.wait_cnt), 1);
        check_eq("t1_nocall",  32'(bus.call_valid), 0);
        step();
        c1 = cyc;
        check_eq("t1_issued1", 32'(bus.issued_ticket), 1);
        check_eq("t1_cvalid",  32'(bus.call_valid), 1);
        check_eq("t1_cteller", 32'(bus.call_teller), 1);
        check_eq("t1_cticket", 32'(bus.call_ticket), 0);
        check_eq("t1_wait2",   32'(bus.wait_cnt), 2);
        step();
        bus.arrive = 1'b0;
        check_eq("t1_issued2", 32'(bus.issued_ticket), 2);
        check_eq("t1_wait_rr", 32'(bus.wait_cnt), 2);
        check_eq("t1_busy",    32'(bus.busy), 3'b001);
        check_eq("t1_pulse",   32'(bus.call_valid), 0);
        check_eq("t1_hold_tl", 32'(bus.call_teller), 1);
        check_eq("t1_seg_dp",  32'(bus.seg), 32'hBF);

        // Round-robin over the remaining free tellers
        wait_call(20, c2);
        check_eq("t2_teller2", 32'(bus.call_teller), 2);
        check_eq("t2_ticket1", 32'(bus.call_ticket), 1);
        check_eq("t2_space1",  32'(c2 - c1), 6);
        wait_call(20, c3);
        check_eq("t2_teller3", 32'(bus.call_teller), 3);
        check_eq("t2_ticket2", 32'(bus.call_ticket), 2);
        check_eq("t2_space2",  32'(c3 - c2), 6);
        step();
        check_eq("t2_wait0",   32'(bus.wait_cnt), 0);
        check_eq("t2_empty",   32'(bus.empty), 1);
        check_eq("t2_busy",    32'(bus.busy), 3'b111);

        // All busy: fill the queue, eighth arrival overflows
        ov_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            bus.arrive = 1'b1;
            step();
            ov_cnt += int'(bus.overflow);
        end
        check_eq("t3_ovf_8th", 32'(bus.overflow), 1);
        bus.arrive = 1'b0;
        step();
        ov_cnt += int'(bus.overflow);
        check_eq("t3_ovf_once", 32'(ov_cnt), 1);
        check_eq("t3_wait7",    32'(bus.wait_cnt), 7);
        check_eq("t3_full",     32'(bus.full), 1);
        check_eq("t3_issued9",  32'(bus.issued_ticket), 9);
        bus.teller_done = 3'b010;
        step();
        bus.teller_done = 3'b000;
        check_eq("t3_busy101",  32'(bus.busy), 3'b101);
        wait_call(20, c4);
        check_eq("t3_teller2",  32'(bus.call_teller), 2);
        check_eq("t3_ticket3",  32'(bus.call_ticket), 3);

        // Arrival at full during CALL is dropped; count drops by the call only
        bus.arrive = 1'b1;
        step();
        bus.arrive = 1'b0;
        check_eq("t4_full_call_wait", 32'(bus.wait_cnt), 6);
        check_eq("t4_full_call_ovf",  32'(bus.overflow), 1);
        check_eq("t4_full_call_iss",  32'(bus.issued_ticket), 9);
        bus.teller_done = 3'b001;
        step();
        bus.teller_done = 3'b000;
        wait_call(20, c5);
        check_eq("t4_teller1", 32'(bus.call_teller), 1);
        check_eq("t4_ticket4", 32'(bus.call_ticket), 4);
        bus.arrive = 1'b1;
        step();
        bus.arrive = 1'b0;
        check_eq("t4_arr_call_wait", 32'(bus.wait_cnt), 6);
        check_eq("t4_arr_call_iss",  32'(bus.issued_ticket), 10);
        check_eq("t4_arr_call_ovf",  32'(bus.overflow), 0);
        check_eq("t4_busy_all",      32'(bus.busy), 3'b111);
        bus.teller_done = 3'b100;
        step();
        check_eq("t4_done_busy",     32'(bus.busy), 3'b011);
        step();
        bus.teller_done = 3'b000;
        check_eq("t4_done_idle",     32'(bus.busy), 3'b011);

        reset = 1'b1;
        step();
        reset = 1'b0;
        check_reset_vals("rst2");

        // Steady arrive/serve traffic across the ticket wrap
        m_issue  = 0;
        m_serve  = 0;
        m_teller = 0;
        for (int n = 0; n < 400 && m_serve < 18; n++) begin
            drive_arr       = ((n % 2) == 0) && ((m_issue - m_serve) < 5);
            bus.arrive      = drive_arr;
            bus.teller_done = 3'b111;
            saw_call        = bus.call_valid;
            wb              = int'(bus.wait_cnt);
            if (saw_call) begin
                check_eq("t5_cticket", 32'(bus.call_ticket), 32'(m_serve % 16));
                check_eq("t5_cteller", 32'(bus.call_teller), 32'(m_teller + 1));
            end
            step();
            if (drive_arr) m_issue++;
            if (saw_call) begin
                m_serve++;
                m_teller = (m_teller + 1) % 3;
            end
            check_eq("t5_invariant", 32'(bus.wait_cnt), 32'(m_issue - m_serve));
            if (drive_arr) check_eq("t5_issued", 32'(bus.issued_ticket), 32'((m_issue - 1) % 16));
            if (saw_call && drive_arr) check_eq("t5_arr_call_wait", 32'(bus.wait_cnt), 32'(wb));
            if (saw_call && m_serve == 16) check_eq("t5_seg_F", 32'(bus.seg), 32'hF1);
            if (saw_call && m_serve == 17) check_eq("t5_seg_0", 32'(bus.seg), 32'hBF);
        end
        bus.arrive      = 1'b0;
        bus.teller_done = 3'b000;
        check_eq("t5_done", 32'(m_serve >= 18), 1);
        check_eq("t6_in_hold", 32'(bus.seg[7]), 1);

        // Reset during HOLD with customers still waiting
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_reset_vals("rst_hold");
        nc = 0;
        repeat (12) begin
            step();
            nc += int'(bus.call_valid);
        end
        check_eq("t6_no_call", 32'(nc), 0);
        check_eq("t6_wait0",   32'(bus.wait_cnt), 0);
        check_eq("t6_empty",   32'(bus.empty), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
`default_nettype wire
